// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg
//   Shared definitions for the stopwatch control block and the datapath top
//   that instantiates it: run-mode state encoding and the default timing
//   constants (10 ms debounce window and 10 ms tick period at 50 MHz).
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_CLEARED = 2'b00,
    ST_RUNNING = 2'b01,
    ST_PAUSED  = 2'b10
  } state_t;

  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 500000;
  localparam int unsigned TICK_DIV_DEFAULT        = 500000;

endpackage

// File: rtl/key_debounce.sv
// key_debounce
//   Conditions one raw active-low board key: 2-flop synchroniser, debounce
//   counter and a one-cycle press pulse on the debounced 1->0 transition.
//   The synchroniser and the debounced level come out of reset at 1, so a
//   key held through reset is seen as a fresh press after the usual latency.
//
// Ports
//   clk    in   system clock
//   reset  in   synchronous, active-high
//   key    in   raw key level, active-low, asynchronous to clk
//   level  out  debounced key level (1 = released)
//   press  out  one-cycle pulse per accepted press (none on release)
module key_debounce
  import stopwatch_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT  // >= 1
) (
  input  logic clk,
  input  logic reset,
  input  logic key,
  output logic level,
  output logic press
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic          level_d;
  logic [CW-1:0] cnt;

  // NOTE: every flop here is updated with <= so all of them sample the
  // pre-edge values; with = the synchroniser would collapse to one stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      level   <= 1'b1;
      level_d <= 1'b1;
      cnt     <= '0;
      press   <= 1'b0;
    end else begin
      sync1   <= key;
      sync2   <= sync1;
      level_d <= level;
      // Edge detect on the registered level: the pulse lands one cycle after
      // the debounced level falls.
      press   <= level_d & ~level;

      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        // This is the DEBOUNCE_CYCLES-th consecutive differing sample.
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl
//   Control/sequencing for the 6-digit stopwatch datapath. Conditions the
//   three board keys, runs the CLEARED/RUNNING/PAUSED mode FSM, divides clk
//   down to the 10 ms counter tick and decides when the display registers
//   follow the counters. All outputs are registered.
//
// Ports
//   clk               in   system clock, 50 MHz
//   reset             in   synchronous, active-high
//   key_reset         in   raw key, active-low: clear the stopwatch
//   key_start_pause   in   raw key, active-low: start / pause / resume
//   key_display_stop  in   raw key, active-low: toggle display freeze
//   cnt_clear         out  datapath counters clear to 0
//   cnt_tick          out  one-cycle pulse advancing the 10 ms digit
//   disp_load         out  display registers copy the counters this cycle
//   state             out  00 CLEARED, 01 RUNNING, 10 PAUSED
//   led               out  [0] running, [1] paused, [2] freeze, [3] key held
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,  // >= 1
  parameter int unsigned TICK_DIV        = TICK_DIV_DEFAULT          // >= 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_reset,
  input  logic       key_start_pause,
  input  logic       key_display_stop,
  output logic       cnt_clear,
  output logic       cnt_tick,
  output logic       disp_load,
  output logic [1:0] state,
  output logic [3:0] led
);

  localparam int unsigned PW = $clog2(TICK_DIV);

  logic reset_level, start_level, display_level;
  logic reset_evt, start_evt, display_evt;

  state_t        st;
  logic          freeze;
  logic [PW-1:0] presc;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_reset (
    .clk   (clk),
    .reset (reset),
    .key   (key_reset),
    .level (reset_level),
    .press (reset_evt)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_start (
    .clk   (clk),
    .reset (reset),
    .key   (key_start_pause),
    .level (start_level),
    .press (start_evt)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_display (
    .clk   (clk),
    .reset (reset),
    .key   (key_display_stop),
    .level (display_level),
    .press (display_evt)
  );

  assign state = st;

  always_ff @(posedge clk) begin
    if (reset) begin
      st        <= ST_CLEARED;
      freeze    <= 1'b0;
      presc     <= '0;
      cnt_clear <= 1'b1;
      cnt_tick  <= 1'b0;
      disp_load <= 1'b1;
      led       <= 4'b0000;
    end else begin
      // Status outputs trail the state they report by one cycle.
      disp_load <= ~freeze;
      led       <= {~(reset_level & start_level & display_level),
                    freeze, st == ST_PAUSED, st == ST_RUNNING};

      if (reset_evt) begin
        // A clear request wins over start/display arriving the same cycle.
        st        <= ST_CLEARED;
        freeze    <= 1'b0;
        presc     <= '0;
        cnt_clear <= 1'b1;
        cnt_tick  <= 1'b0;
      end else begin
        cnt_clear <= 1'b0;
        cnt_tick  <= 1'b0;

        // Prescaler only moves while running, so a pause keeps the partial
        // interval and resume picks up where it stopped.
        if (st == ST_RUNNING) begin
          if (presc == PW'(TICK_DIV - 1)) begin
            presc    <= '0;
            cnt_tick <= 1'b1;
          end else begin
            presc <= presc + 1'b1;
          end
        end

        if (start_evt) begin
          // NOTE: the default arm gives the unused 2'b11 encoding a way back
          // to CLEARED instead of leaving the FSM stuck there.
          case (st)
            ST_CLEARED: st <= ST_RUNNING;
            ST_RUNNING: st <= ST_PAUSED;
            ST_PAUSED:  st <= ST_RUNNING;
            default:    st <= ST_CLEARED;
          endcase
        end

        if (display_evt && st != ST_CLEARED) begin
          freeze <= ~freeze;
        end
      end
    end
  end

endmodule
